// File: rtl/fft_frame_fifo.sv
// Frame-gated FIFO feeding the FFT core: words are released only in whole frames of FRAME_LEN.
// Latency: a word is on dout the cycle after it is written; valid_o rises one edge after level reaches FRAME_LEN.
// Backpressure: writes while full are dropped (sticky overflow); reads are honoured only while valid_o is high.
// Optional frame markers on sof_o/eof_o are built when FFT_FRAME_MARKERS_EN is defined, otherwise tied low.
module fft_frame_fifo #(
    parameter int DATA_W    = 22,
    parameter int DEPTH     = 128,
    parameter int FRAME_LEN = 64,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              overflow,
    output logic [CNT_W-1:0]  level,
    input  logic              flush,
    output logic              valid_o,
    output logic [DATA_W-1:0] dout,
    input  logic              rd_en,
    output logic              sof_o,
    output logic              eof_o
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BEAT_W = $clog2(FRAME_LEN);

    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]  FRAME_C   = CNT_W'(FRAME_LEN);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(FRAME_LEN - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    // Reject configurations the pointer wrap and frame gating cannot support.
    if ((DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("fft_frame_fifo: DEPTH must be a power of two");
    end
    if ((FRAME_LEN > DEPTH) || (FRAME_LEN < 2)) begin : g_frame_chk
        $error("fft_frame_fifo: FRAME_LEN must be in 2..DEPTH");
    end

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [0:0]        state;
    logic [BEAT_W-1:0] beat;

    logic              wr_acc;
    logic              wr_drop;
    logic              rd_acc;
    logic              frame_end;
    logic [CNT_W-1:0]  level_nxt;

    assign valid_o = (state == ST_STREAM);
    assign dout    = mem[rd_ptr];

    // Handshake qualification and next occupancy; flush masks both sides for this cycle.
    always_comb begin
        wr_acc    = wr_en & ~full & ~flush;
        wr_drop   = wr_en & full & ~flush;
        rd_acc    = rd_en & valid_o & ~flush;
        level_nxt = level + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        frame_end = rd_acc & (beat == BEAT_LAST);
    end

    // Storage array: no reset needed, contents are qualified by the pointers.
    always_ff @(posedge CLK) begin
        if (!RST && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and full flag; full follows the next occupancy so it is registered.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == DEPTH_C);
        end
    end

    // Sticky overflow: set by any write that hits a full buffer, cleared only by reset or flush.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            overflow <= 1'b0;
        end else if (wr_drop) begin
            overflow <= 1'b1;
        end
    end

    // Frame gating: start a frame only with a full frame buffered, chain frames while one more is ready.
    always_ff @(posedge CLK) begin
        if (RST || flush) begin
            state <= ST_IDLE;
            beat  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    beat <= '0;
                    if (level >= FRAME_C) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (frame_end) begin
                        beat <= '0;
                        // level_nxt already accounts for this read and any same-cycle write.
                        if (level_nxt < FRAME_C) begin
                            state <= ST_IDLE;
                        end
                    end else if (rd_acc) begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    beat  <= '0;
                end
            endcase
        end
    end

`ifdef FFT_FRAME_MARKERS_EN
    // Frame boundary markers decoded from the registered beat counter.
    always_comb begin
        sof_o = valid_o & (beat == '0);
        eof_o = valid_o & (beat == BEAT_LAST);
    end
`else
    // Markers not built: outputs held low.
    always_comb begin
        sof_o = 1'b0;
        eof_o = 1'b0;
    end
`endif

endmodule
